// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter sharing one 4-bit serial pattern detector among N
// bit-stream requesters; counts overlapping matches per frame.
module seq_detect_arbiter #(
   parameter int         N         = 4,
   parameter int         FRAME_LEN = 16,
   parameter logic [3:0] PATTERN   = 4'b1101,
   parameter int         CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         bit_in,
   input  logic [N-1:0]         bit_valid,
   output logic [N-1:0]         grant,
   output logic                 busy,
   output logic                 hit,
   output logic                 done,
   output logic                 abort,
   output logic [$clog2(N)-1:0] done_id,
   output logic [CNT_W-1:0]     match_count
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [IW-1:0]    last, last_n;
   logic [3:0]       hist, hist_n;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [N-1:0]     grant_n;
   logic             busy_n, hit_n, done_n, abort_n;
   logic [IW-1:0]    done_id_n;
   logic [CNT_W-1:0] match_count_n;

   logic             found;
   logic [IW-1:0]    win;
   logic [3:0]       shifted;
   logic [CNT_W-1:0] bit_cnt_inc;
   int               idx;

   // Rotating search starting just after the previous winner.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(last) + i) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_n       = state;
      last_n        = last;
      hist_n        = hist;
      bit_cnt_n     = bit_cnt;
      cnt_n         = cnt;
      grant_n       = grant;
      busy_n        = busy;
      hit_n         = 1'b0;
      done_n        = 1'b0;
      abort_n       = 1'b0;
      done_id_n     = done_id;
      match_count_n = match_count;
      shifted       = {hist[2:0], bit_in[last]};
      bit_cnt_inc   = bit_cnt + CNT_W'(1);

      case (state)
         RUN: begin
            if (bit_valid[last]) begin
               hist_n    = shifted;
               bit_cnt_n = bit_cnt_inc;
               if (shifted == PATTERN && bit_cnt_inc >= CNT_W'(4)) begin
                  cnt_n = cnt + CNT_W'(1);
                  hit_n = 1'b1;
               end
            end
            // A final bit wins over a simultaneous request drop.
            if (bit_valid[last] && bit_cnt_inc == CNT_W'(FRAME_LEN)) begin
               state_n       = DONE;
               done_n        = 1'b1;
               done_id_n     = last;
               match_count_n = cnt_n;
               grant_n       = '0;
               busy_n        = 1'b0;
            end else if (!req[last]) begin
               state_n   = ABORT;
               abort_n   = 1'b1;
               done_id_n = last;
               grant_n   = '0;
               busy_n    = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            if (found) begin
               state_n      = RUN;
               grant_n      = '0;
               grant_n[win] = 1'b1;
               busy_n       = 1'b1;
               last_n       = win;
               hist_n       = '0;
               bit_cnt_n    = '0;
               cnt_n        = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= IW'(N - 1);
         hist        <= '0;
         bit_cnt     <= '0;
         cnt         <= '0;
         grant       <= '0;
         busy        <= 1'b0;
         hit         <= 1'b0;
         done        <= 1'b0;
         abort       <= 1'b0;
         done_id     <= '0;
         match_count <= '0;
      end else begin
         state       <= state_n;
         last        <= last_n;
         hist        <= hist_n;
         bit_cnt     <= bit_cnt_n;
         cnt         <= cnt_n;
         grant       <= grant_n;
         busy        <= busy_n;
         hit         <= hit_n;
         done        <= done_n;
         abort       <= abort_n;
         done_id     <= done_id_n;
         match_count <= match_count_n;
      end
   end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter: directed frames queue expected
// completion records that a monitor checks on each done/abort pulse.
module tb_seq_detect_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req, bit_in, bit_valid;
   logic [3:0] grant;
   logic       busy, hit, done, abort;
   logic [1:0] done_id;
   logic [7:0] match_count;

   seq_detect_arbiter #(
      .N(4), .FRAME_LEN(16), .PATTERN(4'b1101), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .bit_in(bit_in),
      .bit_valid(bit_valid), .grant(grant), .busy(busy), .hit(hit),
      .done(done), .abort(abort), .done_id(done_id),
      .match_count(match_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ab;
      int id;
      int cnt;
      int hits;
      int bcyc;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   int   hacc   = 0;
   int   bacc   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic push(input bit ab, input int id, input int cnt,
                       input int hits, input int bcyc);
      exp_t e;
      e.ab = ab; e.id = id; e.cnt = cnt; e.hits = hits; e.bcyc = bcyc;
      sb.push_back(e);
   endtask

   // Monitor: accumulates hit/busy cycles per frame, checks on completion.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         hacc = 0;
         bacc = 0;
      end else begin
         hacc += int'(hit);
         bacc += int'(busy);
         if (done || abort) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("kind_abort", int'(abort), int'(e.ab));
               chk("done_id", int'(done_id), e.id);
               chk("match_count", int'(match_count), e.cnt);
               chk("hits", hacc, e.hits);
               if (e.bcyc >= 0) chk("busy_cycles", bacc, e.bcyc);
            end
            hacc = 0;
            bacc = 0;
         end
      end
   end

   task automatic wait_grant(input int id);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (grant[id]) ok = 1'b1;
      end
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   // Stream nb bits MSB-first; optional one-cycle gap between bits.
   task automatic stream(input int id, input logic [15:0] bits,
                         input int nb, input bit gap, input bit keep);
      req[id] = 1'b1;
      wait_grant(id);
      for (int i = 0; i < nb; i++) begin
         bit_valid[id] = 1'b1;
         bit_in[id]    = bits[15-i];
         @(negedge clk);
         if (gap && i < nb - 1) begin
            bit_valid[id] = 1'b0;
            @(negedge clk);
         end
      end
      bit_valid[id] = 1'b0;
      bit_in[id]    = 1'b0;
      if (!keep) req[id] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req = '0; bit_in = '0; bit_valid = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req = '0; bit_in = '0; bit_valid = '0;
      repeat (2) @(negedge clk);
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pulses", int'({hit, done, abort}), 0);
      chk("rst_done_id", int'(done_id), 0);
      chk("rst_match_count", int'(match_count), 0);
      reset = 1'b0;
      @(negedge clk);

      // Back-to-back 1101 pattern, five overlapping matches.
      push(1'b0, 0, 5, 5, 16);
      stream(0, 16'b1101101101101101, 16, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // All ones then a single late match; history starts fresh.
      push(1'b0, 2, 0, 0, 16);
      stream(2, 16'hFFFF, 16, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      push(1'b0, 2, 1, 1, 16);
      stream(2, 16'b0000000000001101, 16, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Continuous requests from 1 and 3 alternate.
      do_reset();
      push(1'b0, 1, 0, 0, 16);
      push(1'b0, 3, 0, 0, 16);
      push(1'b0, 1, 0, 0, 16);
      push(1'b0, 3, 0, 0, 16);
      req = 4'b1010;
      bit_valid = 4'b1010;
      @(negedge clk);
      chk("rr_grant0", int'(grant), 4'b0010);
      for (int k = 0; k < 4; k++) begin
         wait_done();
         if (k == 3) begin
            req = '0;
            bit_valid = '0;
         end else begin
            @(negedge clk);
            chk("rr_regrant", int'(grant), (k % 2 == 0) ? 4'b1000 : 4'b0010);
         end
      end
      repeat (3) @(negedge clk);

      // Gapped valid: 16 accepted bits over 31 busy cycles.
      push(1'b0, 0, 4, 4, 31);
      stream(0, 16'hDDDD, 16, 1'b1, 1'b0);
      repeat (2) @(negedge clk);

      // Drop request after five bits; prior count held.
      push(1'b1, 1, 4, 1, 6);
      stream(1, 16'b1101100000000000, 5, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort_hold_count", int'(match_count), 4);

      // Reset mid-frame clears outputs without a clock edge.
      stream(0, 16'b1101101000000000, 7, 1'b0, 1'b1);
      chk("pre_reset_busy", int'(busy), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_grant", int'(grant), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_match_count", int'(match_count), 0);
      req = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      req = 4'b1111;
      @(negedge clk);
      chk("post_rst_grant", int'(grant), 4'b0001);
      reset = 1'b1;
      req = '0;
      @(negedge clk);
      reset = 1'b0;

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
